// File: rtl/fx68k_bus_responder.sv
// -----------------------------------------------------------------------------
// fx68k_bus_responder
//
// Slave end of the fx68k 68000-style asynchronous bus. Each bus cycle is
// decoded and served from an internal 16-bit word RAM. A programmable number
// of wait states is inserted before DTACKn. Interrupt-acknowledge cycles
// (FC=111) are autovectored with VPAn. Unmapped addresses raise BERRn after a
// timeout. A backdoor load port lets boot logic preload programs and vectors
// while the bus is idle.
//
// Parameters:
//   AW          RAM word-address width (1..22); RAM holds 2**AW words.
//   WAIT_CYCLES extra clk cycles before DTACKn asserts (0..255).
//   BERR_LIMIT  clk cycles an unmapped cycle waits before BERRn (1..65535).
//
// Ports:
//   clk        system clock, rising edge
//   extReset   asynchronous, active-high reset
//   ASn        address strobe, active low
//   eRWn       1 = read, 0 = write
//   UDSn/LDSn  upper/lower data strobes, active low
//   FC0..FC2   function code
//   eab        address bits 23:1
//   oEdb       write data from the CPU
//   iEdb       read data to the CPU (holds its last value between reads)
//   DTACKn     data acknowledge, active low
//   VPAn       valid peripheral address (autovector), active low
//   BERRn      bus error, active low
//   ldEn       backdoor write request, held until ldAck
//   ldAddr     backdoor word address
//   ldData     backdoor write data
//   ldAck      one-cycle pulse when the backdoor write is performed
// -----------------------------------------------------------------------------
module fx68k_bus_responder #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int BERR_LIMIT  = 64
) (
    input  logic          clk,
    input  logic          extReset,
    input  logic          ASn,
    input  logic          eRWn,
    input  logic          UDSn,
    input  logic          LDSn,
    input  logic          FC0,
    input  logic          FC1,
    input  logic          FC2,
    input  logic [23:1]   eab,
    input  logic [15:0]   oEdb,
    output logic [15:0]   iEdb,
    output logic          DTACKn,
    output logic          VPAn,
    output logic          BERRn,
    input  logic          ldEn,
    input  logic [AW-1:0] ldAddr,
    input  logic [15:0]   ldData,
    output logic          ldAck
);

    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);
    localparam logic [15:0] BERR_LIM  = 16'(BERR_LIMIT);

    typedef enum logic [2:0] {
        IDLE,   // waiting for ASn
        WAIT,   // wait states, then strobe qualification
        ACK,    // DTACKn asserted until ASn rises
        VPA,    // autovector acknowledge until ASn rises
        TOUT,   // unmapped address, counting towards bus error
        BERR    // BERRn asserted until ASn rises
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    cnt, cnt_nx;
    logic [15:0]   tcnt, tcnt_nx;

    logic          mapped;
    logic          iack;
    logic [AW-1:0] idx;

    // Per-edge actions decided by the next-state logic.
    logic          rd_en;
    logic          wr_hi;
    logic          wr_lo;
    logic          ld_go;

    logic [15:0]   mem [2**AW];

    assign mapped = (eab[23:AW+1] == '0);
    assign idx    = eab[AW:1];
    assign iack   = ({FC2, FC1, FC0} == 3'b111);

    // -------------------------------------------------------------------------
    // Next-state and per-edge action decode
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tcnt_nx  = tcnt;
        rd_en    = 1'b0;
        wr_hi    = 1'b0;
        wr_lo    = 1'b0;
        ld_go    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!ASn) begin
                    // A new bus cycle wins over a pending backdoor load.
                    if (iack) begin
                        state_nx = VPA;
                    end else if (mapped) begin
                        state_nx = WAIT;
                        cnt_nx   = WAIT_INIT;
                    end else begin
                        state_nx = TOUT;
                        tcnt_nx  = 16'd1;
                    end
                end else if (ldEn && !extReset) begin
                    ld_go = 1'b1;
                end
            end

            WAIT: begin
                if (ASn) begin
                    // Cycle aborted: nothing is written or acknowledged.
                    state_nx = IDLE;
                end else if (cnt != 8'd0) begin
                    cnt_nx = cnt - 8'd1;
                end else if (eRWn) begin
                    state_nx = ACK;
                    rd_en    = 1'b1;
                end else if (!UDSn || !LDSn) begin
                    // Writes leave WAIT on this edge, so the RAM write
                    // happens exactly once per cycle.
                    state_nx = ACK;
                    wr_hi    = !UDSn;
                    wr_lo    = !LDSn;
                end
                // Write with both strobes still high: the CPU asserts the
                // data strobes after AS, so keep waiting for them.
            end

            TOUT: begin
                if (ASn) begin
                    state_nx = IDLE;
                end else if (tcnt == BERR_LIM) begin
                    state_nx = BERR;
                end else begin
                    tcnt_nx = tcnt + 16'd1;
                end
            end

            ACK, VPA, BERR: begin
                if (ASn) begin
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counters and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge extReset) begin
        if (extReset) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            tcnt   <= 16'd0;
            DTACKn <= 1'b1;
            VPAn   <= 1'b1;
            BERRn  <= 1'b1;
            ldAck  <= 1'b0;
            iEdb   <= 16'h0000;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            tcnt   <= tcnt_nx;
            // Strobes are decoded from the next state so each asserts on the
            // same edge that enters its state; only one state drives each,
            // which keeps the three responses mutually exclusive.
            DTACKn <= (state_nx != ACK);
            VPAn   <= (state_nx != VPA);
            BERRn  <= (state_nx != BERR);
            ldAck  <= ld_go;
            if (rd_en) begin
                iEdb <= mem[idx];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word RAM: byte-lane bus writes plus the backdoor load
    // -------------------------------------------------------------------------
    // NOTE: the RAM array is deliberately left out of reset; contents survive
    // extReset and the array maps onto plain memory without a reset network.
    always_ff @(posedge clk) begin
        if (ld_go) begin
            mem[ldAddr] <= ldData;
        end
        if (wr_hi) begin
            mem[idx][15:8] <= oEdb[15:8];
        end
        if (wr_lo) begin
            mem[idx][7:0] <= oEdb[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // Protocol invariants
    // -------------------------------------------------------------------------
    a_one_response: assert property (@(posedge clk) disable iff (extReset)
        $countones({~DTACKn, ~VPAn, ~BERRn}) <= 1);

    a_no_load_during_cycle: assert property (@(posedge clk) disable iff (extReset)
        ld_go |-> (state == IDLE && ASn));

endmodule

// File: tb/tb_fx68k_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_fx68k_bus_responder
//
// Self-checking bench for fx68k_bus_responder with default parameters
// (AW=10, WAIT_CYCLES=2, BERR_LIMIT=64). Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge. Read data
// expectations travel through a queue: pushed when the cycle is driven,
// popped when DTACKn shows the data is valid.
// -----------------------------------------------------------------------------
module tb_fx68k_bus_responder;

    localparam int AW          = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int BERR_LIMIT  = 64;

    logic          clk = 1'b0;
    logic          extReset;
    logic          ASn, eRWn, UDSn, LDSn, FC0, FC1, FC2;
    logic [23:1]   eab;
    logic [15:0]   oEdb;
    logic [15:0]   iEdb;
    logic          DTACKn, VPAn, BERRn;
    logic          ldEn;
    logic [AW-1:0] ldAddr;
    logic [15:0]   ldData;
    logic          ldAck;

    int            checks    = 0;
    int            failures  = 0;
    int            excl_viol = 0;
    logic [15:0]   exp_q[$];

    typedef struct {
        bit          we;
        logic [23:1] addr;
        logic [15:0] wdata;
        bit          udsn;
        bit          ldsn;
        int          dly;    // cycles between ASn and the data strobes
        logic [15:0] exp;    // expected read data (reads only)
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    fx68k_bus_responder #(
        .AW(AW), .WAIT_CYCLES(WAIT_CYCLES), .BERR_LIMIT(BERR_LIMIT)
    ) dut (
        .clk(clk), .extReset(extReset),
        .ASn(ASn), .eRWn(eRWn), .UDSn(UDSn), .LDSn(LDSn),
        .FC0(FC0), .FC1(FC1), .FC2(FC2),
        .eab(eab), .oEdb(oEdb), .iEdb(iEdb),
        .DTACKn(DTACKn), .VPAn(VPAn), .BERRn(BERRn),
        .ldEn(ldEn), .ldAddr(ldAddr), .ldData(ldData), .ldAck(ldAck)
    );

    // At most one of the three response strobes may be low.
    always @(negedge clk) begin
        if (int'(!DTACKn) + int'(!VPAn) + int'(!BERRn) > 1) excl_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_bus();
        ASn  = 1'b1;
        eRWn = 1'b1;
        UDSn = 1'b1;
        LDSn = 1'b1;
        {FC2, FC1, FC0} = 3'b101;
        eab  = '0;
        oEdb = 16'h0000;
    endtask

    task automatic backdoor(input logic [AW-1:0] a, input logic [15:0] d);
        int n;
        n      = 0;
        ldEn   = 1'b1;
        ldAddr = a;
        ldData = d;
        do begin step(); n++; end while (!ldAck && n < 20);
        check("ld_ack_latency", n, 1);
        ldEn = 1'b0;
        step();
        check("ld_ack_pulse", ldAck, 0);
    endtask

    // Drives a read and stops in ACK with DTACKn low.
    task automatic bus_read(input logic [23:1] a, input logic [15:0] exp);
        int n;
        logic [15:0] want;
        n    = 0;
        ASn  = 1'b0;
        eRWn = 1'b1;
        UDSn = 1'b0;
        LDSn = 1'b0;
        eab  = a;
        exp_q.push_back(exp);
        do begin step(); n++; end while (DTACKn && n < 32);
        check("rd_latency", n, WAIT_CYCLES + 2);
        want = exp_q.pop_front();
        check("rd_data", iEdb, want);
    endtask

    // Drives a write whose data strobes follow ASn by dly cycles; stops in ACK.
    task automatic bus_write(input logic [23:1] a, input logic [15:0] d,
                             input bit udsn, input bit ldsn, input int dly);
        int n;
        int early;
        int want_n;
        n     = 0;
        early = 0;
        ASn   = 1'b0;
        eRWn  = 1'b0;
        UDSn  = 1'b1;
        LDSn  = 1'b1;
        eab   = a;
        oEdb  = d;
        for (int i = 0; i < dly; i++) begin
            step();
            n++;
            if (!DTACKn) early++;
        end
        check("wr_wait_for_ds", early, 0);
        UDSn = udsn;
        LDSn = ldsn;
        while (DTACKn && n < 32) begin step(); n++; end
        want_n = ((dly > WAIT_CYCLES + 1) ? dly : WAIT_CYCLES + 1) + 1;
        check("wr_latency", n, want_n);
    endtask

    // ACK must hold while ASn stays low, then release one edge after ASn rises.
    task automatic bus_release();
        logic [15:0] held;
        held = iEdb;
        step();
        check("ack_hold", DTACKn, 0);
        idle_bus();
        step();
        check("ack_release", DTACKn, 1);
        check("iedb_kept", iEdb, held);
    endtask

    task automatic unmapped_berr(input logic [23:1] a);
        int n;
        int dt_low;
        n      = 0;
        dt_low = 0;
        ASn    = 1'b0;
        eRWn   = 1'b1;
        UDSn   = 1'b0;
        LDSn   = 1'b0;
        eab    = a;
        do begin
            step();
            n++;
            if (!DTACKn) dt_low++;
        end while (BERRn && n < 200);
        check("berr_latency", n, BERR_LIMIT + 1);
        check("berr_no_dtack", dt_low, 0);
        repeat (2) step();
        check("berr_hold", BERRn, 0);
        idle_bus();
        step();
        check("berr_release", BERRn, 1);
    endtask

    initial begin
        int lows;
        vecs[0] = '{0, 23'h000004, 16'h0000, 0, 0, 0, 16'h1234};
        vecs[1] = '{1, 23'h000010, 16'hABCD, 1, 0, 2, 16'h0000};
        vecs[2] = '{0, 23'h000010, 16'h0000, 0, 0, 0, 16'h12CD};
        vecs[3] = '{1, 23'h000020, 16'hA1B2, 0, 1, 5, 16'h0000};
        vecs[4] = '{0, 23'h000020, 16'h0000, 0, 0, 0, 16'hA155};
        vecs[5] = '{0, 23'h0003FF, 16'h0000, 0, 0, 0, 16'hBEEF};
        vecs[6] = '{1, 23'h0003FF, 16'h0F0F, 0, 0, 0, 16'h0000};
        vecs[7] = '{0, 23'h0003FF, 16'h0000, 0, 0, 0, 16'h0F0F};
        vecs[8] = '{1, 23'h000004, 16'hCAFE, 0, 0, 0, 16'h0000};
        vecs[9] = '{0, 23'h000004, 16'h0000, 0, 0, 0, 16'hCAFE};

        // Reset values
        extReset = 1'b1;
        idle_bus();
        ldEn   = 1'b0;
        ldAddr = '0;
        ldData = 16'h0000;
        repeat (2) step();
        check("rst_dtackn", DTACKn, 1);
        check("rst_vpan", VPAn, 1);
        check("rst_berrn", BERRn, 1);
        check("rst_iedb", iEdb, 16'h0000);
        check("rst_ldack", ldAck, 0);
        extReset = 1'b0;
        step();

        // Preload through the backdoor
        backdoor(10'h004, 16'h1234);
        backdoor(10'h010, 16'h1200);
        backdoor(10'h020, 16'h5555);
        backdoor(10'h3FF, 16'hBEEF);
        backdoor(10'h030, 16'h0001);

        // Table-driven reads and byte-lane writes
        foreach (vecs[i]) begin
            if (vecs[i].we) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].udsn, vecs[i].ldsn, vecs[i].dly);
            else            bus_read(vecs[i].addr, vecs[i].exp);
            bus_release();
        end

        // Backdoor request colliding with a bus cycle start is deferred
        ldEn   = 1'b1;
        ldAddr = 10'h030;
        ldData = 16'h7777;
        bus_read(23'h000030, 16'h0001);
        bus_release();
        check("ld_deferred", ldAck, 0);
        step();
        check("ld_after_cycle", ldAck, 1);
        ldEn = 1'b0;
        step();
        check("ld_after_pulse", ldAck, 0);
        bus_read(23'h000030, 16'h7777);
        bus_release();

        // Interrupt acknowledge: autovector, no RAM access
        ASn  = 1'b0;
        eRWn = 1'b0;
        UDSn = 1'b0;
        LDSn = 1'b0;
        {FC2, FC1, FC0} = 3'b111;
        eab  = 23'h000004;
        oEdb = 16'hDEAD;
        step();
        check("vpa_on", VPAn, 0);
        check("vpa_no_dtack", DTACKn, 1);
        check("vpa_no_berr", BERRn, 1);
        repeat (3) step();
        check("vpa_hold", VPAn, 0);
        idle_bus();
        step();
        check("vpa_release", VPAn, 1);
        bus_read(23'h000004, 16'hCAFE);
        bus_release();

        // Unmapped: bus error after the timeout, both just past the RAM and far away
        unmapped_berr(23'h400000);
        unmapped_berr(23'h000400);

        // Unmapped cycle released before the timeout raises nothing
        ASn  = 1'b0;
        eRWn = 1'b1;
        UDSn = 1'b0;
        LDSn = 1'b0;
        eab  = 23'h400000;
        lows = 0;
        repeat (20) begin
            step();
            if (!BERRn || !DTACKn) lows++;
        end
        idle_bus();
        repeat (BERR_LIMIT + 10) begin
            step();
            if (!BERRn || !DTACKn) lows++;
        end
        check("tout_abort_quiet", lows, 0);

        // Write aborted inside the wait count
        ASn  = 1'b0;
        eRWn = 1'b0;
        UDSn = 1'b0;
        LDSn = 1'b0;
        eab  = 23'h000004;
        oEdb = 16'h0000;
        lows = 0;
        step();
        if (!DTACKn) lows++;
        idle_bus();
        repeat (4) begin
            step();
            if (!DTACKn) lows++;
        end
        check("abort_wait_no_dtack", lows, 0);
        bus_read(23'h000004, 16'hCAFE);
        bus_release();

        // Write aborted while waiting for the data strobes
        ASn  = 1'b0;
        eRWn = 1'b0;
        UDSn = 1'b1;
        LDSn = 1'b1;
        eab  = 23'h000004;
        oEdb = 16'h1111;
        lows = 0;
        repeat (5) begin
            step();
            if (!DTACKn) lows++;
        end
        idle_bus();
        repeat (2) begin
            step();
            if (!DTACKn) lows++;
        end
        check("abort_ds_no_dtack", lows, 0);
        bus_read(23'h000004, 16'hCAFE);
        bus_release();

        // Asynchronous reset while in ACK; RAM keeps its contents
        bus_write(23'h000010, 16'h5A5A, 0, 0, 0);
        bus_release();
        bus_read(23'h000010, 16'h5A5A);
        #2 extReset = 1'b1;
        #1;
        check("areset_dtackn", DTACKn, 1);
        check("areset_iedb", iEdb, 16'h0000);
        idle_bus();
        step();
        extReset = 1'b0;
        step();
        bus_read(23'h000010, 16'h5A5A);
        bus_release();

        check("one_response_at_a_time", excl_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
